// File: rtl/masked_and_dom.sv
// ============================================================================
//  Module   : masked_and_dom
//  Brief    : W-lane, D-share domain-oriented masked AND with an enable/done
//             handshake; cross-domain products refreshed by per-lane randomness.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module masked_and_dom #(
    parameter  int D = 2,
    parameter  int W = 1,
    localparam int R = D * (D - 1) / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           AndEnable,
    input  logic [D*W-1:0] ina,
    input  logic [D*W-1:0] inb,
    input  logic [R*W-1:0] rin,
    output logic [D*W-1:0] out,
    output logic           AndDone
);

    localparam int c_T    = D * D * W;
    localparam int c_ST_W = 2;

    typedef enum logic [c_ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_COMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [D*W-1:0]   r_a_q, w_a_d;
    logic [D*W-1:0]   r_b_q, w_b_d;
    logic [R*W-1:0]   r_r_q, w_r_d;
    logic [c_T-1:0]   r_t_q, w_t_d;
    logic [D*W-1:0]   r_out_q, w_out_d;
    logic             r_done_q, w_done_d;

    logic [c_T-1:0]   w_term;
    logic [D*W-1:0]   w_comp;

    // Term for lane l, domain pair (i,j) lives at w_term[(l*D+i)*D+j]
    for (genvar l = 0; l < W; l++) begin : g_lane
        for (genvar i = 0; i < D; i++) begin : g_row
            for (genvar j = 0; j < D; j++) begin : g_col
                if (i == j) begin : g_diag
                    assign w_term[(l*D+i)*D+j] = r_a_q[i*W+l] & r_b_q[j*W+l];
                end else begin : g_cross
                    localparam int c_LO = (i < j) ? i : j;
                    localparam int c_HI = (i < j) ? j : i;
                    localparam int c_K  = c_LO*D - c_LO*(c_LO+1)/2 + (c_HI-c_LO-1);
                    assign w_term[(l*D+i)*D+j] = (r_a_q[i*W+l] & r_b_q[j*W+l])
                                               ^ r_r_q[l*R+c_K];
                end
            end
        end
    end

    // Compression reads only registered terms, so no path from ina/inb to out
    always_comb begin
        w_comp = '0;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < D; i++) begin
                for (int j = 0; j < D; j++) begin
                    w_comp[i*W+l] = w_comp[i*W+l] ^ r_t_q[(l*D+i)*D+j];
                end
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_r_d     = r_r_q;
        w_t_d     = r_t_q;
        w_out_d   = r_out_q;
        w_done_d  = r_done_q;
        case (r_state_q)
            ST_IDLE: begin
                w_done_d = 1'b0;
                if (AndEnable) begin
                    w_a_d     = ina;
                    w_b_d     = inb;
                    w_r_d     = rin;
                    w_state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                if (!AndEnable) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_t_d     = w_term;
                    w_state_d = ST_COMP;
                end
            end
            ST_COMP: begin
                if (!AndEnable) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_out_d   = w_comp;
                    w_done_d  = 1'b1;
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!AndEnable) begin
                    w_done_d  = 1'b0;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_done_d  = 1'b0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_r_q     <= '0;
            r_t_q     <= '0;
            r_out_q   <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_r_q     <= w_r_d;
            r_t_q     <= w_t_d;
            r_out_q   <= w_out_d;
            r_done_q  <= w_done_d;
        end
    end

    assign out     = r_out_q;
    assign AndDone = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_masked_and_dom.sv
// ============================================================================
//  Module   : tb_masked_and_dom
//  Brief    : Directed/table-driven bench for masked_and_dom (D=2,W=1 and D=3,W=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_masked_and_dom;

    logic        clk = 1'b0;
    logic        rst;
    logic        en2, done2;
    logic [1:0]  ina2, inb2, out2;
    logic [0:0]  rin2;
    logic        en3, done3;
    logic [11:0] ina3, inb3, rin3, out3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    masked_and_dom #(.D(2), .W(1)) dut2 (
        .clk(clk), .rst(rst), .AndEnable(en2), .ina(ina2), .inb(inb2),
        .rin(rin2), .out(out2), .AndDone(done2)
    );

    masked_and_dom #(.D(3), .W(4)) dut3 (
        .clk(clk), .rst(rst), .AndEnable(en3), .ina(ina3), .inb(inb3),
        .rin(rin3), .out(out3), .AndDone(done3)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       r;
        logic [1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model2(input logic [1:0] a, input logic [1:0] b, input logic r);
        model2[0] = (a[0] & b[0]) ^ ((a[0] & b[1]) ^ r);
        model2[1] = ((a[1] & b[0]) ^ r) ^ (a[1] & b[1]);
    endfunction

    function automatic int kidx3(input int i, input int j);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        kidx3 = lo*3 - lo*(lo+1)/2 + (hi-lo-1);
    endfunction

    function automatic logic [11:0] model3(input logic [11:0] a, input logic [11:0] b, input logic [11:0] r);
        logic [11:0] o;
        logic        t;
        o = '0;
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    t = a[i*4+l] & b[j*4+l];
                    if (i != j) t = t ^ r[l*3 + kidx3(i, j)];
                    o[i*4+l] = o[i*4+l] ^ t;
                end
        return o;
    endfunction

    // One D=2 transaction: request, latency/result check, optional hold, one-edge drop
    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic r,
                        input logic [1:0] exp, input int hold, input string tag);
        int         n;
        logic [1:0] held;
        logic       stable;
        ina2 = a; inb2 = b; rin2 = r; en2 = 1'b1;
        @(posedge clk); #1;
        ina2 = ~a; inb2 = ~b; rin2 = ~r;
        n = 1;
        while (!done2 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s latency", tag), n, 3);
        chk($sformatf("%s out", tag), out2, exp);
        held = out2;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!done2 || out2 !== held) stable = 1'b0;
        end
        chk($sformatf("%s hold", tag), stable, 1);
        en2 = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s drop done", tag), done2, 0);
        chk($sformatf("%s drop out", tag), out2, held);
    endtask

    task automatic run3(input logic [11:0] a, input logic [11:0] b, input logic [11:0] r,
                        output logic [11:0] res);
        int         n;
        logic [3:0] got, want;
        ina3 = a; inb3 = b; rin3 = r; en3 = 1'b1;
        n = 0;
        while (!done3 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("d3 latency", n, 3);
        chk("d3 out", out3, model3(a, b, r));
        for (int l = 0; l < 4; l++) begin
            got[l]  = out3[l] ^ out3[4+l] ^ out3[8+l];
            want[l] = (a[l] ^ a[4+l] ^ a[8+l]) & (b[l] ^ b[4+l] ^ b[8+l]);
        end
        chk("d3 lane xor", got, want);
        res = out3;
        en3 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        vecs [7];
        logic [1:0]  a, b, prior;
        logic        r, seen;
        int          n;
        logic [11:0] x, y, z, o1, o2;

        vecs[0] = '{a: 2'b01, b: 2'b11, r: 1'b0, exp: 2'b00};
        vecs[1] = '{a: 2'b01, b: 2'b11, r: 1'b1, exp: 2'b11};
        vecs[2] = '{a: 2'b11, b: 2'b01, r: 1'b0, exp: 2'b11};
        vecs[3] = '{a: 2'b10, b: 2'b10, r: 1'b0, exp: 2'b10};
        vecs[4] = '{a: 2'b10, b: 2'b10, r: 1'b1, exp: 2'b01};
        vecs[5] = '{a: 2'b11, b: 2'b11, r: 1'b1, exp: 2'b11};
        vecs[6] = '{a: 2'b00, b: 2'b11, r: 1'b1, exp: 2'b11};

        rst = 1'b1; en2 = 1'b0; en3 = 1'b0;
        ina2 = '0; inb2 = '0; rin2 = '0;
        ina3 = '0; inb3 = '0; rin3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out2", out2, 0);
        chk("reset done2", done2, 0);
        chk("reset out3", out3, 0);
        chk("reset done3", done3, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++)
            run2(vecs[v].a, vecs[v].b, vecs[v].r, vecs[v].exp, 0, $sformatf("vec%0d", v));

        for (int c = 0; c < 32; c++) begin
            a = c[1:0]; b = c[3:2]; r = c[4];
            run2(a, b, r, model2(a, b, r), 0, $sformatf("exh%0d", c));
            chk($sformatf("exh%0d parity", c), ^out2, (^a) & (^b));
        end

        // Abort from MULT: result register must keep the previous transaction
        run2(2'b11, 2'b01, 1'b0, 2'b11, 0, "pre-abort");
        prior = out2;
        ina2 = 2'b01; inb2 = 2'b11; rin2 = 1'b0; en2 = 1'b1;
        @(posedge clk); #1;
        en2 = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done2) seen = 1'b1;
        end
        chk("abort done", seen, 0);
        chk("abort out", out2, prior);

        // Reset while in COMP, then confirm the FSM restarts from IDLE
        en2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst comp out", out2, 0);
        chk("rst comp done", done2, 0);
        rst = 1'b0;
        n = 0;
        while (!done2 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("post-rst latency", n, 3);
        chk("post-rst out", out2, 2'b00);
        en2 = 1'b0;
        @(posedge clk); #1;

        run2(2'b10, 2'b10, 1'b1, 2'b01, 10, "hold");
        run2(2'b11, 2'b11, 1'b1, 2'b11, 0, "retrig");

        for (int t = 0; t < 1000; t++) begin
            x = 12'($urandom); y = 12'($urandom); z = 12'($urandom);
            run3(x, y, z, o1);
        end

        x = 12'hA5C; y = 12'h3F1;
        run3(x, y, 12'h000, o1);
        run3(x, y, 12'h6B3, o2);
        chk("rin dependence", (o1 != o2), 1);
        chk("rin same product", (o1[3:0]^o1[7:4]^o1[11:8]), (o2[3:0]^o2[7:4]^o2[11:8]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
